iq_chirp_mod: RTL and testbench

- Parametrised successor to the single-tone DDS IQ modulator.
- Phase-accumulator I/Q generator with an internal linear-FM (chirp) sweep engine (CW, single, sawtooth, triangle), so the external LFM phase stream is no longer needed.
- Per-channel static phase offset, per-sample phase modulation, amplitude scaling, DC level, saturation.
- Drives the I/Q DAC interface directly.

---
 rtl/iq_mod_pkg.sv | 20 ++
 rtl/iq_sin_lut.sv | 22 ++
 rtl/iq_chirp_mod.sv | 130 +++++++++++++
 tb/tb_iq_chirp_mod.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/iq_mod_pkg.sv
// iq_mod_pkg: shared helper, sweep modes and FSM encoding for the chirp I/Q modulator.
// LFSR constants exist only when IQ_PHASE_DITHER_EN is defined.
package iq_mod_pkg;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
   localparam logic [1:0] MODE_CW     = 2'd0;
   localparam logic [1:0] MODE_SINGLE = 2'd1;
   localparam logic [1:0] MODE_SAW    = 2'd2;
   localparam logic [1:0] MODE_TRI    = 2'd3;
   typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DOWN, ST_HOLD} state_e;
`ifdef IQ_PHASE_DITHER_EN
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // feedback taps x^16 + x^14 + x^13 + x^11
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
`endif
endpackage

// File: rtl/iq_sin_lut.sv
// iq_sin_lut: registered full-wave signed sine ROM; contents computed at elaboration.
module iq_sin_lut import iq_mod_pkg::*; #(
   parameter int BIT_DEPTH = 10,
   parameter int ADDR_MAX = 1024,
   localparam int AW = clog2(ADDR_MAX)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        en_i,
   input  logic [AW-1:0]               addr_i,
   output logic signed [BIT_DEPTH-1:0] data_o
);
   localparam real AMPL = real'((1 << (BIT_DEPTH - 1)) - 1);
   localparam real PI = 3.14159265358979323846;
   logic signed [BIT_DEPTH-1:0] rom [ADDR_MAX];
   for (genvar a = 0; a < ADDR_MAX; a++) begin : g_rom
      assign rom[a] = BIT_DEPTH'($rtoi($floor(AMPL * $sin(2.0 * PI * a / ADDR_MAX) + 0.5)));
   end
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) data_o <= '0;
      else if (en_i) data_o <= rom[addr_i];
endmodule

// File: rtl/iq_chirp_mod.sv
// iq_chirp_mod: DDS I/Q modulator with internal linear-FM sweep engine, offset-binary DAC outputs.
// Define IQ_PHASE_DITHER_EN to add LFSR dither to the accumulator ahead of address truncation.
module iq_chirp_mod import iq_mod_pkg::*; #(
   parameter int BIT_DEPTH = 10,
   parameter int ADDR_MAX = 1024,
   parameter int AMP_DEPTH = 8,
   parameter int ACC_FRAC = 8,
   localparam int AW = clog2(ADDR_MAX),
   localparam int FW = AW + ACC_FRAC
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 en_in,
   input  logic                 start_in,
   input  logic [1:0]           mode_in,
   input  logic [FW-1:0]        step_start,
   input  logic [FW-1:0]        step_stop,
   input  logic [FW-1:0]        step_inc,
   input  logic [AW-1:0]        phase_zero_I,
   input  logic [AW-1:0]        phase_zero_Q,
   input  logic [AW-1:0]        phase_I,
   input  logic [AW-1:0]        phase_Q,
   input  logic [AMP_DEPTH-1:0] amp_coef_I,
   input  logic [AMP_DEPTH-1:0] amp_coef_Q,
   input  logic [BIT_DEPTH-1:0] zero_lvl_I,
   input  logic [BIT_DEPTH-1:0] zero_lvl_Q,
   output logic [BIT_DEPTH-1:0] I,
   output logic [BIT_DEPTH-1:0] Q,
   output logic                 valid_out,
   output logic                 busy_out,
   output logic                 done_out
);
   localparam int PW = BIT_DEPTH + AMP_DEPTH + 1;
   state_e state_q, state_d;
   logic [1:0] mode_q, mode_d;
   logic [FW-1:0] freq_q, freq_d, acc_q, acc_d;
   logic done_q, done_d;
   logic [3:0] vld_q;
   logic [FW:0] up_sum, dn_lim;
   logic [AW-1:0] base;
   logic adv, degen, hit_up, hit_dn;
   assign adv = en_in && state_q != ST_IDLE;
   assign up_sum = {1'b0, freq_q} + {1'b0, step_inc};
   assign dn_lim = {1'b0, step_start} + {1'b0, step_inc};
   assign degen = step_stop <= step_start || step_inc == '0;
   assign hit_up = up_sum >= {1'b0, step_stop};
   assign hit_dn = {1'b0, freq_q} <= dn_lim;
   always_comb begin
      state_d = state_q;
      mode_d = mode_q;
      freq_d = freq_q;
      acc_d = adv ? acc_q + freq_q : acc_q;
      done_d = 1'b0;
      if (en_in) begin
         if (start_in) begin
            mode_d = mode_in;
            freq_d = step_start;
            acc_d = '0;
            state_d = (mode_in == MODE_CW || degen) ? ST_HOLD : ST_UP;
         end else if ((state_q == ST_UP || state_q == ST_DOWN) && degen) begin
            state_d = ST_HOLD;
            freq_d = step_start;
         end else if (state_q == ST_UP && hit_up) begin
            freq_d = mode_q == MODE_SAW ? step_start : step_stop;
            state_d = mode_q == MODE_SINGLE ? ST_HOLD : mode_q == MODE_TRI ? ST_DOWN : ST_UP;
            done_d = mode_q == MODE_SINGLE;
         end else if (state_q == ST_UP) begin
            freq_d = up_sum[FW-1:0];
         end else if (state_q == ST_DOWN) begin
            freq_d = hit_dn ? step_start : freq_q - step_inc;
            state_d = hit_dn ? ST_UP : ST_DOWN;
         end
      end
   end
   always_ff @(posedge clk_in or posedge rst_in)
      if (rst_in) begin
         state_q <= ST_IDLE;
         mode_q <= MODE_CW;
         freq_q <= '0;
         acc_q <= '0;
         done_q <= 1'b0;
         vld_q <= '0;
      end else begin
         state_q <= state_d;
         mode_q <= mode_d;
         freq_q <= freq_d;
         acc_q <= acc_d;
         done_q <= done_d;
         if (adv) vld_q <= {vld_q[2:0], 1'b1};
      end
`ifdef IQ_PHASE_DITHER_EN
   logic [15:0] lfsr_q;
   logic [FW-1:0] acc_dith;
   always_ff @(posedge clk_in or posedge rst_in)
      if (rst_in) lfsr_q <= LFSR_SEED;
      else if (en_in) lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
   assign acc_dith = acc_q + FW'(lfsr_q[ACC_FRAC-1:0]);
   assign base = acc_dith[FW-1:ACC_FRAC];
`else
   assign base = acc_q[FW-1:ACC_FRAC];
`endif
   // per channel: address -> LUT -> scale -> offset/clamp, all stalled together by adv
   for (genvar c = 0; c < 2; c++) begin : g_ch
      logic [AW-1:0] addr_q;
      logic signed [BIT_DEPTH-1:0] lut;
      logic signed [PW-1:0] prod, scl_q;
      logic signed [PW:0] sum;
      logic [BIT_DEPTH-1:0] out_q;
      iq_sin_lut #(.BIT_DEPTH(BIT_DEPTH), .ADDR_MAX(ADDR_MAX)) u_lut (
         .clk_i(clk_in), .rst_i(rst_in), .en_i(adv), .addr_i(addr_q), .data_o(lut)
      );
      assign prod = lut * $signed({1'b0, c == 0 ? amp_coef_I : amp_coef_Q});
      assign sum = $signed({1'b0, c == 0 ? zero_lvl_I : zero_lvl_Q}) + scl_q;
      always_ff @(posedge clk_in or posedge rst_in)
         if (rst_in) begin
            addr_q <= '0;
            scl_q <= '0;
            out_q <= '0;
         end else if (adv) begin
            addr_q <= base + (c == 0 ? phase_zero_I : phase_zero_Q) + (c == 0 ? phase_I : phase_Q);
            scl_q <= prod >>> (AMP_DEPTH - 1);
            out_q <= sum[PW] ? '0 : |sum[PW-1:BIT_DEPTH] ? '1 : sum[BIT_DEPTH-1:0];
         end
   end
   assign I = g_ch[0].out_q;
   assign Q = g_ch[1].out_q;
   assign valid_out = vld_q[3] && adv;
   assign busy_out = state_q == ST_UP || state_q == ST_DOWN;
   assign done_out = done_q;
endmodule

// File: tb/tb_iq_chirp_mod.sv
// tb_iq_chirp_mod: randomized scoreboard bench for iq_chirp_mod against a behavioural sweep/sine model.
module tb_iq_chirp_mod;
   localparam int AF = 8;
   localparam int AW = 10;
   localparam int FW = 18;
   logic clk_in = 0, rst_in = 0, en_in = 0, start_in = 0;
   logic [1:0] mode_in = 0;
   logic [FW-1:0] step_start = 0, step_stop = 0, step_inc = 0;
   logic [AW-1:0] phase_zero_I = 0, phase_zero_Q = 0, phase_I = 0, phase_Q = 0;
   logic [7:0] amp_coef_I = 0, amp_coef_Q = 0;
   logic [9:0] zero_lvl_I = 0, zero_lvl_Q = 0;
   logic [9:0] I, Q;
   logic valid_out, busy_out, done_out;

   iq_chirp_mod dut (
      .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in), .start_in(start_in), .mode_in(mode_in),
      .step_start(step_start), .step_stop(step_stop), .step_inc(step_inc),
      .phase_zero_I(phase_zero_I), .phase_zero_Q(phase_zero_Q), .phase_I(phase_I), .phase_Q(phase_Q),
      .amp_coef_I(amp_coef_I), .amp_coef_Q(amp_coef_Q), .zero_lvl_I(zero_lvl_I), .zero_lvl_Q(zero_lvl_Q),
      .I(I), .Q(Q), .valid_out(valid_out), .busy_out(busy_out), .done_out(done_out)
   );

   always #5 clk_in = ~clk_in;

   int errors = 0, checks = 0, done_cnt = 0;
   typedef struct {int i; int q;} smp_t;
   smp_t exp_q[$];
   bit m_active, m_sweep, m_fall, m_done;
   int m_mode, m_freq, m_acc;
   bit rnd_ph, rnd_en;

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int dac(int addr, int amp, int zl);
      real x = 511.0 * $sin(2.0 * 3.14159265358979323846 * addr / 1024.0);
      int s = x >= 0.0 ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
      int p = s * amp;
      int sc = p >= 0 ? p / 128 : -((-p + 127) / 128);
      int v = zl + sc;
      return v < 0 ? 0 : v > 1023 ? 1023 : v;
   endfunction

   task automatic model_reset();
      m_active = 0; m_sweep = 0; m_fall = 0; m_done = 0;
      m_mode = 0; m_freq = 0; m_acc = 0;
      exp_q.delete();
   endtask

   // one enabled clock of the reference: emit sample from current phase, then advance sweep
   task automatic model_step();
      int a;
      bit degen;
      if (rst_in) begin
         model_reset();
         return;
      end
      m_done = 0;
      if (!en_in) return;
      if (m_active) begin
         a = m_acc >> AF;
         exp_q.push_back('{i: dac((a + phase_zero_I + phase_I) % 1024, amp_coef_I, zero_lvl_I),
                           q: dac((a + phase_zero_Q + phase_Q) % 1024, amp_coef_Q, zero_lvl_Q)});
      end
      degen = step_stop <= step_start || step_inc == 0;
      if (start_in) begin
         m_mode = mode_in; m_freq = step_start; m_acc = 0; m_active = 1;
         m_sweep = mode_in != 0 && !degen; m_fall = 0;
         return;
      end
      if (m_active) m_acc = (m_acc + m_freq) % (1 << FW);
      if (!m_sweep) return;
      if (degen) begin
         m_sweep = 0; m_freq = step_start;
      end else if (!m_fall) begin
         if (m_freq + step_inc >= step_stop) begin
            if (m_mode == 1) begin m_freq = step_stop; m_sweep = 0; m_done = 1; end
            else if (m_mode == 2) m_freq = step_start;
            else begin m_freq = step_stop; m_fall = 1; end
         end else m_freq = m_freq + step_inc;
      end else if (m_freq <= step_start + step_inc) begin
         m_freq = step_start; m_fall = 0;
      end else m_freq = m_freq - step_inc;
   endtask

   initial forever begin
      @(posedge clk_in);
      model_step();
   end

   initial begin
      smp_t s;
      forever begin
         @(negedge clk_in);
         if (rst_in) continue;
         chk("busy", busy_out, m_sweep);
         chk("done", done_out, m_done);
         if (done_out) done_cnt++;
         if (!en_in) chk("valid_stalled", valid_out, 0);
         else if (valid_out) begin
            if (exp_q.size() == 0) chk("unexpected_valid", valid_out, 0);
            else begin
               s = exp_q.pop_front();
               chk("I", I, s.i);
               chk("Q", Q, s.q);
            end
         end
      end
   end

   task automatic cyc(int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
         if (rnd_ph) begin phase_I = AW'($urandom); phase_Q = AW'($urandom); end
         if (rnd_en) en_in = $urandom_range(0, 3) != 0;
      end
   endtask

   task automatic start(int mode);
      mode_in = 2'(mode); en_in = 1; start_in = 1;
      cyc(1);
      start_in = 0;
   endtask

   task automatic do_reset();
      rst_in = 1;
      cyc(2);
      rst_in = 0; en_in = 1; done_cnt = 0;
   endtask

   task automatic wait_valid(string name);
      int lat = 0;
      while (!valid_out && lat < 10) begin lat++; cyc(1); end
      chk(name, lat, 4);
   endtask

   task automatic rand_cfg();
      amp_coef_I = 8'($urandom); amp_coef_Q = 8'($urandom);
      zero_lvl_I = 10'($urandom); zero_lvl_Q = 10'($urandom);
      phase_zero_I = AW'($urandom); phase_zero_Q = AW'($urandom);
   endtask

   initial begin
      #1 rst_in = 1;
      #1;
      chk("rst_I", I, 0); chk("rst_Q", Q, 0);
      chk("rst_valid", valid_out, 0); chk("rst_busy", busy_out, 0); chk("rst_done", done_out, 0);
      @(posedge clk_in);
      #1 rst_in = 0; en_in = 1;
      cyc(6);
      chk("idle_valid", valid_out, 0);
      chk("idle_I", I, 0);
      // CW tone, quadrature offset on Q
      step_start = FW'('h100); amp_coef_I = 128; amp_coef_Q = 128;
      zero_lvl_I = 512; zero_lvl_Q = 512; phase_zero_Q = 256;
      start(0);
      wait_valid("cw_latency");
      chk("cw_first_I", I, 512); chk("cw_first_Q", Q, 1023);
      cyc(2100);
      chk("cw_inflight", exp_q.size(), 4);
      // saturation on I
      do_reset();
      amp_coef_I = 255;
      start(0);
      wait_valid("sat_latency");
      cyc(256); chk("sat_hi", I, 1023);
      cyc(512); chk("sat_lo", I, 0);
      // single sweep
      do_reset();
      rand_cfg(); rnd_ph = 1;
      step_stop = FW'('h200); step_inc = 1;
      start(1);
      begin
         int n = 0;
         while (busy_out && n < 1000) begin n++; cyc(1); end
         chk("single_busy_len", n, 256);
      end
      cyc(300);
      chk("single_done_cnt", done_cnt, 1);
      chk("single_inflight", exp_q.size(), 4);
      // triangle with stall and restart
      do_reset();
      rand_cfg();
      start(3);
      cyc(300); en_in = 0; cyc(10); en_in = 1; cyc(400);
      start(3);
      cyc(700);
      chk("tri_inflight", exp_q.size(), 4);
      chk("tri_done_cnt", done_cnt, 0);
      // sawtooth under random enable, then asynchronous reset
      start(2);
      rnd_en = 1; cyc(800); rnd_en = 0; en_in = 1; cyc(5);
      chk("saw_inflight", exp_q.size(), 4);
      @(posedge clk_in);
      #3 rst_in = 1;
      #1;
      chk("arst_I", I, 0); chk("arst_Q", Q, 0); chk("arst_valid", valid_out, 0);
      chk("arst_busy", busy_out, 0); chk("arst_done", done_out, 0);
      cyc(2);
      rst_in = 0; done_cnt = 0;
      cyc(20);
      chk("post_rst_valid", valid_out, 0); chk("post_rst_busy", busy_out, 0);
      // degenerate sweep words
      step_stop = step_start;
      start(1);
      chk("degen_busy", busy_out, 0);
      cyc(50);
      chk("degen_done_cnt", done_cnt, 0);
      chk("degen_inflight", exp_q.size(), 4);
      // randomized sweeps
      for (int it = 0; it < 6; it++) begin
         do_reset();
         rand_cfg();
         step_start = FW'($urandom_range(0, 'h3F000));
         step_stop = step_start + FW'($urandom_range(0, 'h800));
         step_inc = FW'($urandom_range(0, 16));
         start(it % 4);
         rnd_en = 1; cyc(500);
         start(it % 4);
         cyc(200);
         rnd_en = 0; en_in = 1; cyc(5);
         chk("rand_inflight", exp_q.size(), 4);
      end
      rnd_ph = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
